fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch byte address after reset.
REQ-002 The block SHALL have parameter NOP_INSN, default 16'hBF00, the instruction presented to decode when no valid instruction is available.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port i_stall, input, 1, decode-stage stall; holds the decode outputs.
REQ-006 The block SHALL have port i_branch_met, input, 1, redirect request from execute.
REQ-007 The block SHALL have port i_branch_addr, input, 32, redirect byte address, sampled when i_branch_met=1.
REQ-008 The block SHALL have port o_imem_req, output, 1, instruction memory request.
REQ-009 The block SHALL have port o_imem_addr, output, 32, request byte address, halfword aligned.
REQ-010 The block SHALL have port i_imem_ack, input, 1, request accepted with data valid in the same cycle.
REQ-011 The block SHALL have port i_imem_rdata, input, 16, instruction halfword, valid when i_imem_ack=1.
REQ-012 The block SHALL have port o_ir_id, output, 16, registered instruction to decode.
REQ-013 The block SHALL have port o_pc_id, output, 32, registered byte address of o_ir_id.
REQ-014 The block SHALL have port o_valid_id, output, 1, o_ir_id holds a real fetched instruction.

Function
REQ-015 The block SHALL keep a fetch PC register; o_imem_addr SHALL equal the fetch PC, with bit 0 always 0.
REQ-016 The block SHALL buffer fetched instructions and their addresses in a 2-entry FIFO.
REQ-017 The block SHALL allow at most one outstanding memory request.
REQ-018 The block SHALL assert o_imem_req only when the FIFO occupancy, counting the outstanding request, is below 2.
REQ-019 Once o_imem_req is asserted, o_imem_req and o_imem_addr SHALL stay stable until the cycle i_imem_ack=1.
REQ-020 On an ack in state RUN, the block SHALL push {rdata, addr} into the FIFO and advance the fetch PC by 2, wrapping modulo 2^32.
REQ-021 On a clock edge with i_stall=0 and i_branch_met=0, if the FIFO is non-empty, the block SHALL pop the head into o_ir_id/o_pc_id and set o_valid_id=1.
REQ-022 On a clock edge with i_stall=0 and i_branch_met=0, if the FIFO is empty, the block SHALL load o_ir_id=NOP_INSN, set o_valid_id=0, and hold o_pc_id.
REQ-023 A push and a pop in the same cycle SHALL both take effect, including an empty-FIFO bypass where the acked data goes directly to o_ir_id.
REQ-024 When i_stall=1 and i_branch_met=0, the block SHALL hold o_ir_id/o_pc_id/o_valid_id; fetching continues until the FIFO is full.
REQ-025 The FSM SHALL have two states, RUN and FLUSH.
REQ-026 When i_branch_met=1, regardless of i_stall, the block SHALL clear the FIFO, set o_ir_id=NOP_INSN and o_valid_id=0, and load the fetch PC with {i_branch_addr[31:1],1'b0}.
REQ-027 If a request is outstanding without an ack when i_branch_met=1, the FSM SHALL go RUN->FLUSH.
REQ-028 In FLUSH, the block SHALL keep the old request stable, discard its data on ack, and return FLUSH->RUN; the branch-target request SHALL start the following cycle.
REQ-029 An ack in the same cycle as i_branch_met=1 SHALL have its data discarded, with no FLUSH entry.
REQ-030 A further i_branch_met=1 while in FLUSH SHALL overwrite the target PC and remain in FLUSH.

Reset
REQ-031 Asserting rst low at any time, including mid-request or in FLUSH, SHALL immediately force: fetch PC=RESET_PC, FIFO empty, state RUN, o_imem_req=0, o_ir_id=NOP_INSN, o_pc_id=RESET_PC, o_valid_id=0.
REQ-032 After rst deasserts, the first request SHALL be issued on the first clock edge with o_imem_addr=RESET_PC.

Verification
REQ-033 The bench SHALL cover sequential fetch: zero-wait memory returns 0x1111, 0x2222, 0x3333 -> o_ir_id shows them on consecutive cycles with o_pc_id 0x0, 0x2, 0x4 and o_valid_id=1.
REQ-034 The bench SHALL cover stall fill: i_stall=1 for 5 cycles -> exactly 2 buffered plus the held IR, o_imem_req=0 while the FIFO is full, and no instruction is lost or duplicated after release.
REQ-035 The bench SHALL cover branch with a pending request: 3-cycle ack latency, branch to 0x100 mid-request -> the old data is discarded, the next request is at 0x100, and o_valid_id=0 until 0x100 is decoded.
REQ-036 The bench SHALL cover branch with a simultaneous ack: the acked data never appears at o_ir_id, and the next request is at the target.
REQ-037 The bench SHALL cover wrap-around: a branch to 0xFFFFFFFE -> the next fetch address is 0x00000000.
REQ-038 The bench SHALL cover asynchronous reset: rst low mid-request in FLUSH -> all outputs reach their reset values without a clock edge, and the first request after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Halfword instruction fetch: 2-entry prefetch FIFO feeding registered decode outputs, with branch flush.
// Latency: acked data reaches o_ir_id on the same edge when the FIFO is empty; stall holds decode and fills the FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [15:0] NOP_INSN = 16'hBF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_branch_met,
  input  logic [31:0] i_branch_addr,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_ir_id,
  output logic [31:0] o_pc_id,
  output logic        o_valid_id
);

  typedef enum logic {RUN, FLUSH} state_t;

  typedef struct packed {
    logic [15:0] ir;
    logic [31:0] pc;
  } entry_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic        req;
  entry_t      fifo [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        ack;
  logic [31:0] br_pc;
  logic        pop_fifo;
  logic        bypass;
  logic        write_fifo;
  logic [1:0]  count_nxt;

  assign o_imem_req  = req;
  assign o_imem_addr = pc & 32'hFFFF_FFFE;

  assign ack        = req & i_imem_ack;
  assign br_pc      = i_branch_addr & 32'hFFFF_FFFE;
  assign pop_fifo   = ~i_stall & (count != 2'd0);
  assign bypass     = ~i_stall & (count == 2'd0) & ack;
  assign write_fifo = ack & ~bypass;
  assign count_nxt  = count + {1'b0, write_fifo} - {1'b0, pop_fifo};

  always_ff @(posedge clk) begin
    if (state == RUN && !i_branch_met && write_fifo)
      fifo[wr_ptr] <= '{ir: i_imem_rdata, pc: o_imem_addr};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      tgt        <= RESET_PC;
      req        <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      o_ir_id    <= NOP_INSN;
      o_pc_id    <= RESET_PC;
      o_valid_id <= 1'b0;
    end else if (i_branch_met) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      o_ir_id    <= NOP_INSN;
      o_valid_id <= 1'b0;
      // An unacked request must stay on the bus, so park the target until it drains.
      if (req && !ack) begin
        state <= FLUSH;
        tgt   <= br_pc;
      end else begin
        state <= RUN;
        pc    <= br_pc;
        req   <= 1'b1;
      end
    end else if (state == FLUSH) begin
      if (!i_stall) begin
        o_ir_id    <= NOP_INSN;
        o_valid_id <= 1'b0;
      end
      if (ack) begin
        state <= RUN;
        pc    <= tgt;
        req   <= 1'b1;
      end
    end else begin
      if (!i_stall) begin
        if (count != 2'd0) begin
          o_ir_id    <= fifo[rd_ptr].ir;
          o_pc_id    <= fifo[rd_ptr].pc;
          o_valid_id <= 1'b1;
        end else if (ack) begin
          o_ir_id    <= i_imem_rdata;
          o_pc_id    <= o_imem_addr;
          o_valid_id <= 1'b1;
        end else begin
          o_ir_id    <= NOP_INSN;
          o_valid_id <= 1'b0;
        end
      end
      if (pop_fifo)   rd_ptr <= ~rd_ptr;
      if (write_fifo) wr_ptr <= ~wr_ptr;
      count <= count_nxt;
      if (ack) pc <= pc + 32'd2;
      // A new request is only issued if its data is guaranteed a FIFO slot.
      req <= (req & ~ack) | (count_nxt < 2'd2);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall fill, branch flush, wrap-around and async reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall;
  logic        i_branch_met;
  logic [31:0] i_branch_addr;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [15:0] i_imem_rdata;
  logic [15:0] o_ir_id;
  logic [31:0] o_pc_id;
  logic        o_valid_id;

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  int wcnt;

  localparam logic [15:0] NOP = 16'hBF00;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (i_stall),
    .i_branch_met (i_branch_met),
    .i_branch_addr(i_branch_addr),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_ir_id      (o_ir_id),
    .o_pc_id      (o_pc_id),
    .o_valid_id   (o_valid_id)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_of(input logic [31:0] a);
    case (a)
      32'h0:   mem_of = 16'h1111;
      32'h2:   mem_of = 16'h2222;
      32'h4:   mem_of = 16'h3333;
      32'h6:   mem_of = 16'h4444;
      32'h8:   mem_of = 16'h5555;
      32'hA:   mem_of = 16'h6666;
      32'hC:   mem_of = 16'h7777;
      default: mem_of = a[15:0] ^ 16'h8000;
    endcase
  endfunction

  // Memory model: ack after lat cycles of request (lat<=1 means same cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           wcnt <= 0;
    else if (o_imem_req && !i_imem_ack) wcnt <= wcnt + 1;
    else                                wcnt <= 0;
  end

  assign i_imem_ack   = o_imem_req && ((wcnt + 1) >= lat);
  assign i_imem_rdata = mem_of(o_imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [15:0] ir, input logic [31:0] pc, input logic v);
    check({tag, "_ir"}, {16'h0, o_ir_id}, {16'h0, ir});
    check({tag, "_pc"}, o_pc_id, pc);
    check({tag, "_valid"}, {31'h0, o_valid_id}, {31'h0, v});
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    check({tag, "_req"}, {31'h0, o_imem_req}, {31'h0, r});
    if (r) check({tag, "_addr"}, o_imem_addr, a);
  endtask

  initial begin
    rst = 1'b1; i_stall = 1'b0; i_branch_met = 1'b0; i_branch_addr = 32'h0;
    #1 rst = 1'b0;
    #1;
    chk_id("reset", NOP, 32'h0, 1'b0);
    check("reset_req", {31'h0, o_imem_req}, 32'h0);
    check("reset_addr", o_imem_addr, 32'h0);
    step(); step();
    rst = 1'b1;

    // sequential zero-wait fetch
    step(); chk_req("e0", 1'b1, 32'h0);
    step(); chk_id("seq0", 16'h1111, 32'h0, 1'b1);
    step(); chk_id("seq1", 16'h2222, 32'h2, 1'b1);
    step(); chk_id("seq2", 16'h3333, 32'h4, 1'b1); chk_req("seq2", 1'b1, 32'h6);

    // stall fill: two buffered, requests stop when full
    i_stall = 1'b1;
    step(); chk_id("st1", 16'h3333, 32'h4, 1'b1); chk_req("st1", 1'b1, 32'h8);
    step(); chk_req("st2", 1'b0, 32'h0);
    step(); step(); step();
    chk_id("st5", 16'h3333, 32'h4, 1'b1); chk_req("st5", 1'b0, 32'h0);
    i_stall = 1'b0;
    step(); chk_id("rel1", 16'h4444, 32'h6, 1'b1); chk_req("rel1", 1'b1, 32'hA);
    step(); chk_id("rel2", 16'h5555, 32'h8, 1'b1);
    step(); chk_id("rel3", 16'h6666, 32'hA, 1'b1);

    // branch with pending request, 3-cycle latency
    lat = 3;
    step(); chk_id("b0", 16'h7777, 32'hC, 1'b1); chk_req("b0", 1'b1, 32'hE);
    i_branch_met = 1'b1; i_branch_addr = 32'h100;
    step(); chk_id("b1", NOP, 32'hC, 1'b0); chk_req("b1", 1'b1, 32'hE);
    i_branch_met = 1'b0;
    step(); chk_id("b2", NOP, 32'hC, 1'b0); chk_req("b2", 1'b1, 32'h100);
    step(); check("b3_valid", {31'h0, o_valid_id}, 32'h0);
    step(); check("b4_valid", {31'h0, o_valid_id}, 32'h0);
    step(); chk_id("b5", 16'h8100, 32'h100, 1'b1);

    // branch with simultaneous ack, target forces wrap-around
    lat = 0;
    i_branch_met = 1'b1; i_branch_addr = 32'hFFFF_FFFF;
    step(); chk_id("w1", NOP, 32'h100, 1'b0); chk_req("w1", 1'b1, 32'hFFFF_FFFE);
    i_branch_met = 1'b0;
    step(); chk_id("w2", 16'h7FFE, 32'hFFFF_FFFE, 1'b1); chk_req("w2", 1'b1, 32'h0);

    // flush, re-branch inside flush, then async reset inside flush
    lat = 3;
    i_branch_met = 1'b1; i_branch_addr = 32'h200;
    step(); chk_req("f1", 1'b1, 32'h0); check("f1_valid", {31'h0, o_valid_id}, 32'h0);
    i_branch_addr = 32'h300;
    step(); chk_req("f2", 1'b1, 32'h0);
    i_branch_met = 1'b0;
    step(); chk_req("f3", 1'b1, 32'h300);
    i_branch_met = 1'b1; i_branch_addr = 32'h200;
    step(); chk_req("f4", 1'b1, 32'h300);
    i_branch_met = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_id("arst", NOP, 32'h0, 1'b0);
    check("arst_req", {31'h0, o_imem_req}, 32'h0);
    check("arst_addr", o_imem_addr, 32'h0);
    step();
    rst = 1'b1;
    step(); chk_req("post", 1'b1, 32'h0);
    step(); check("post_wait", {31'h0, o_valid_id}, 32'h0);
    step();
    step(); chk_id("post_data", 16'h1111, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
